// File: rtl/tb_cmd_sequencer.sv
// Command sequencer for testbench sub-modules: issues one command at a time,
// waits for completion, abort or timeout, and reports status and cycle count.
module tb_cmd_sequencer #(
  parameter int unsigned NB_MODULES = 4,
  parameter int unsigned SEL_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_cmd_valid,
  output logic                  o_cmd_ready,
  input  logic [SEL_WIDTH-1:0]  i_cmd_sel,
  input  logic [31:0]           i_cmd_timeout,
  input  logic                  i_abort,
  output logic [NB_MODULES-1:0] o_sel,
  output logic                  o_args_valid,
  input  logic [NB_MODULES-1:0] i_done,
  output logic                  o_busy,
  output logic                  o_status_valid,
  output logic [1:0]            o_status,
  output logic [31:0]           o_cycles
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_REPORT
  } state_t;

  typedef enum logic [1:0] {
    ST_OK      = 2'b00,
    ST_TIMEOUT = 2'b01,
    ST_BAD_SEL = 2'b10,
    ST_ABORTED = 2'b11
  } status_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [SEL_WIDTH-1:0]  r_sel;
  logic [31:0]           r_timeout;
  logic [31:0]           r_cnt;
  logic [31:0]           w_cnt_now;
  status_t               r_status;
  status_t               w_rep_status;
  logic [31:0]           r_cycles;
  logic [31:0]           w_rep_cycles;
  logic                  w_rep_load;
  logic                  w_accept;
  logic                  w_sel_ok;
  logic                  w_done_sel;
  logic [NB_MODULES-1:0] w_onehot;

  always_comb begin
    w_onehot = '0;
    for (int unsigned i = 0; i < NB_MODULES; i++) begin
      w_onehot[i] = (32'(r_sel) == i);
    end
  end

  // w_cnt_now is the count of the current WAIT cycle (first WAIT cycle = 1);
  // it saturates rather than wrapping when no timeout is armed.
  assign w_cnt_now  = (&r_cnt) ? r_cnt : r_cnt + 32'd1;
  assign w_accept   = (r_state == S_IDLE) && i_cmd_valid;
  assign w_sel_ok   = (32'(i_cmd_sel) < NB_MODULES);
  assign w_done_sel = |(i_done & w_onehot);

  always_comb begin
    w_state_nxt  = r_state;
    w_rep_load   = 1'b0;
    w_rep_status = ST_OK;
    w_rep_cycles = '0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (w_sel_ok) begin
            w_state_nxt = S_ISSUE;
          end else begin
            w_state_nxt  = S_REPORT;
            w_rep_load   = 1'b1;
            w_rep_status = ST_BAD_SEL;
          end
        end
      end
      S_ISSUE: w_state_nxt = S_WAIT;
      S_WAIT: begin
        // Priority on a shared cycle: done, then abort, then timeout.
        if (w_done_sel) begin
          w_state_nxt  = S_REPORT;
          w_rep_load   = 1'b1;
          w_rep_status = ST_OK;
          w_rep_cycles = w_cnt_now;
        end else if (i_abort) begin
          w_state_nxt  = S_REPORT;
          w_rep_load   = 1'b1;
          w_rep_status = ST_ABORTED;
          w_rep_cycles = w_cnt_now;
        end else if ((r_timeout != '0) && (w_cnt_now == r_timeout)) begin
          w_state_nxt  = S_REPORT;
          w_rep_load   = 1'b1;
          w_rep_status = ST_TIMEOUT;
          w_rep_cycles = w_cnt_now;
        end
      end
      S_REPORT: w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_sel     <= '0;
      r_timeout <= '0;
      r_cnt     <= '0;
      r_status  <= ST_OK;
      r_cycles  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_sel     <= i_cmd_sel;
        r_timeout <= i_cmd_timeout;
      end
      if (r_state == S_ISSUE) begin
        r_cnt <= '0;
      end else if (r_state == S_WAIT) begin
        r_cnt <= w_cnt_now;
      end
      if (w_rep_load) begin
        r_status <= w_rep_status;
        r_cycles <= w_rep_cycles;
      end
    end
  end

  assign o_cmd_ready    = (r_state == S_IDLE);
  assign o_busy         = (r_state != S_IDLE);
  assign o_sel          = ((r_state == S_ISSUE) || (r_state == S_WAIT)) ? w_onehot : '0;
  assign o_args_valid   = (r_state == S_ISSUE);
  assign o_status_valid = (r_state == S_REPORT);
  assign o_status       = r_status;
  assign o_cycles       = r_cycles;

endmodule

// File: tb/tb_tb_cmd_sequencer.sv
// Bench for tb_cmd_sequencer: directed vector table, reset and back-to-back
// sequences, then random commands checked against a transaction-level model.
module tb_tb_cmd_sequencer;

  localparam int unsigned NB = 4;
  localparam int unsigned SW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          i_cmd_valid;
  logic          o_cmd_ready;
  logic [SW-1:0] i_cmd_sel;
  logic [31:0]   i_cmd_timeout;
  logic          i_abort;
  logic [NB-1:0] o_sel;
  logic          o_args_valid;
  logic [NB-1:0] i_done;
  logic          o_busy;
  logic          o_status_valid;
  logic [1:0]    o_status;
  logic [31:0]   o_cycles;

  tb_cmd_sequencer #(
    .NB_MODULES(NB),
    .SEL_WIDTH (SW)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_cmd_valid   (i_cmd_valid),
    .o_cmd_ready   (o_cmd_ready),
    .i_cmd_sel     (i_cmd_sel),
    .i_cmd_timeout (i_cmd_timeout),
    .i_abort       (i_abort),
    .o_sel         (o_sel),
    .o_args_valid  (o_args_valid),
    .i_done        (i_done),
    .o_busy        (o_busy),
    .o_status_valid(o_status_valid),
    .o_status      (o_status),
    .o_cycles      (o_cycles)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [1:0]  last_st;
  logic [31:0] last_cyc;

  typedef struct {
    logic [3:0]  sel;
    logic [31:0] t;
    int          done_k;
    int          abort_k;
    logic [3:0]  noise;
    logic [1:0]  st;
    int          k;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_out(input string tag, input logic rdy, input logic [3:0] sel,
                         input logic args, input logic sv);
    chk({tag, "_ready"}, o_cmd_ready, rdy);
    chk({tag, "_busy"}, o_busy, !rdy);
    chk({tag, "_sel"}, o_sel, sel);
    chk({tag, "_args_valid"}, o_args_valid, args);
    chk({tag, "_status_valid"}, o_status_valid, sv);
  endtask

  function automatic logic [3:0] onehot(input logic [3:0] s);
    logic [3:0] one;
    one = 4'b0001;
    return (32'(s) < NB) ? (one << s) : 4'b0000;
  endfunction

  // Outcome is the earliest WAIT cycle with an event; on a tie the more
  // important event keeps it (done, then abort, then timeout).
  function automatic void model(input logic [3:0] sel, input logic [31:0] t, input int dk,
                                input int ak, output logic [1:0] st, output int k);
    if (32'(sel) >= NB) begin
      st = 2'b10;
      k  = 0;
      return;
    end
    k  = 1 << 30;
    st = 2'b00;
    if (dk > 0) begin
      k  = dk;
      st = 2'b00;
    end
    if (ak > 0 && ak < k) begin
      k  = ak;
      st = 2'b11;
    end
    if (t != 0 && int'(t) < k) begin
      k  = int'(t);
      st = 2'b01;
    end
  endfunction

  task automatic run_cmd(input logic [3:0] sel, input logic [31:0] t, input int dk,
                         input int ak, input logic [3:0] noise, input logic [1:0] est,
                         input int ek);
    logic [3:0] oh;
    oh = onehot(sel);
    @(negedge clk);
    chk_out("idle", 1'b1, 4'b0, 1'b0, 1'b0);
    chk("idle_status_hold", 32'(o_status), 32'(last_st));
    chk("idle_cycles_hold", o_cycles, last_cyc);
    i_cmd_valid   = 1'b1;
    i_cmd_sel     = sel;
    i_cmd_timeout = t;
    i_done        = 4'($urandom);
    i_abort       = 1'($urandom);
    if (oh != 4'b0) begin
      @(negedge clk);
      chk_out("issue", 1'b0, oh, 1'b1, 1'b0);
      i_cmd_valid   = 1'($urandom);
      i_cmd_sel     = 4'($urandom);
      i_cmd_timeout = $urandom;
      i_done        = 4'($urandom);
      i_abort       = 1'($urandom);
      for (int k = 1; k <= ek; k++) begin
        @(negedge clk);
        chk_out("wait", 1'b0, oh, 1'b0, 1'b0);
        i_done        = (noise & ~oh) | ((k == dk) ? oh : 4'b0);
        i_abort       = (k == ak);
        i_cmd_valid   = 1'($urandom);
        i_cmd_sel     = 4'($urandom);
        i_cmd_timeout = $urandom;
      end
    end
    @(negedge clk);
    chk_out("report", 1'b0, 4'b0, 1'b0, 1'b1);
    chk("report_status", 32'(o_status), 32'(est));
    chk("report_cycles", o_cycles, 32'(ek));
    last_st     = est;
    last_cyc    = 32'(ek);
    i_cmd_valid = 1'b0;
    i_done      = '0;
    i_abort     = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t       vecs[10];
    logic [3:0] sel;
    logic [31:0] t;
    int         dk, ak, ek;
    logic [1:0] est;

    vecs[0] = '{4'd2,  32'd10, 3, 0, 4'b0000, 2'b00, 3};
    vecs[1] = '{4'd1,  32'd5,  0, 0, 4'b1101, 2'b01, 5};
    vecs[2] = '{4'd6,  32'd9,  0, 0, 4'b0000, 2'b10, 0};
    vecs[3] = '{4'd0,  32'd4,  4, 4, 4'b0000, 2'b00, 4};
    vecs[4] = '{4'd0,  32'd4,  0, 4, 4'b1000, 2'b11, 4};
    vecs[5] = '{4'd3,  32'd0,  1, 0, 4'b0111, 2'b00, 1};
    vecs[6] = '{4'd15, 32'd0,  0, 0, 4'b0000, 2'b10, 0};
    vecs[7] = '{4'd2,  32'd7,  0, 7, 4'b0000, 2'b11, 7};
    vecs[8] = '{4'd3,  32'd1,  0, 0, 4'b1111 ^ 4'b1000, 2'b01, 1};
    vecs[9] = '{4'd0,  32'd0,  0, 20, 4'b1110, 2'b11, 20};

    rst_n         = 1'b0;
    i_cmd_valid   = 1'b1;
    i_cmd_sel     = 4'd1;
    i_cmd_timeout = 32'd3;
    i_done        = 4'b1111;
    i_abort       = 1'b1;
    last_st       = 2'b00;
    last_cyc      = '0;
    repeat (2) begin
      @(negedge clk);
      chk_out("reset", 1'b1, 4'b0, 1'b0, 1'b0);
      chk("reset_status", 32'(o_status), 32'd0);
      chk("reset_cycles", o_cycles, 32'd0);
    end
    rst_n       = 1'b1;
    i_cmd_valid = 1'b0;
    i_done      = '0;
    i_abort     = 1'b0;

    foreach (vecs[i]) begin
      run_cmd(vecs[i].sel, vecs[i].t, vecs[i].done_k, vecs[i].abort_k,
              vecs[i].noise, vecs[i].st, vecs[i].k);
    end

    // Reset in the middle of a T=0 wait drops the command without a report.
    @(negedge clk);
    chk_out("rw_idle", 1'b1, 4'b0, 1'b0, 1'b0);
    i_cmd_valid = 1'b1; i_cmd_sel = 4'd3; i_cmd_timeout = 32'd0;
    @(negedge clk);
    chk_out("rw_issue", 1'b0, 4'b1000, 1'b1, 1'b0);
    i_cmd_valid = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      chk_out("rw_wait", 1'b0, 4'b1000, 1'b0, 1'b0);
      i_done = 4'b0111;
      if (k == 7) rst_n = 1'b0;
    end
    i_cmd_valid = 1'b1; i_cmd_sel = 4'd1;
    repeat (2) begin
      @(negedge clk);
      chk_out("rw_reset", 1'b1, 4'b0, 1'b0, 1'b0);
      chk("rw_reset_status", 32'(o_status), 32'd0);
      chk("rw_reset_cycles", o_cycles, 32'd0);
    end
    rst_n = 1'b1; i_cmd_valid = 1'b1; i_cmd_sel = 4'd2; i_cmd_timeout = 32'd0; i_done = '0;
    @(negedge clk);
    chk_out("rw_post_issue", 1'b0, 4'b0100, 1'b1, 1'b0);
    i_cmd_valid = 1'b0;
    @(negedge clk);
    chk_out("rw_post_wait", 1'b0, 4'b0100, 1'b0, 1'b0);
    i_done = 4'b0100;
    @(negedge clk);
    chk_out("rw_post_report", 1'b0, 4'b0, 1'b0, 1'b1);
    chk("rw_post_status", 32'(o_status), 32'd0);
    chk("rw_post_cycles", o_cycles, 32'd1);
    i_done = '0;

    // Valid held high with done on the first WAIT cycle: one command per 4 cycles.
    @(negedge clk);
    i_cmd_valid = 1'b1; i_cmd_sel = 4'd1; i_cmd_timeout = 32'd0; i_done = 4'b0010;
    for (int n = 0; n < 16; n++) begin
      case (n % 4)
        0: chk_out("b2b_idle",   1'b1, 4'b0000, 1'b0, 1'b0);
        1: chk_out("b2b_issue",  1'b0, 4'b0010, 1'b1, 1'b0);
        2: chk_out("b2b_wait",   1'b0, 4'b0010, 1'b0, 1'b0);
        default: begin
          chk_out("b2b_report", 1'b0, 4'b0000, 1'b0, 1'b1);
          chk("b2b_status", 32'(o_status), 32'd0);
          chk("b2b_cycles", o_cycles, 32'd1);
        end
      endcase
      @(negedge clk);
    end
    chk_out("b2b_end", 1'b1, 4'b0, 1'b0, 1'b0);
    i_cmd_valid = 1'b0; i_done = '0;
    last_st = 2'b00; last_cyc = 32'd1;

    for (int n = 0; n < 250; n++) begin
      sel = 4'($urandom_range(0, 7));
      t   = ($urandom_range(0, 3) == 0) ? 32'd0 : 32'($urandom_range(1, 12));
      dk  = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 12));
      ak  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 12)) : 0;
      if (t == 0 && dk == 0 && ak == 0) dk = int'($urandom_range(1, 12));
      model(sel, t, dk, ak, est, ek);
      run_cmd(sel, t, dk, ak, 4'($urandom), est, ek);
      if ($urandom_range(0, 3) == 0) begin
        @(negedge clk);
        chk_out("gap", 1'b1, 4'b0, 1'b0, 1'b0);
        i_done  = 4'($urandom);
        i_abort = 1'($urandom);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tb_cmd_sequencer.md
TB_CMD_SEQUENCER -- requirements
Module: tb_cmd_sequencer

Interface
REQ-001 Parameter NB_MODULES, default 4: number of testbench sub-modules (wait, set, check, ...) sequenced; legal range 2..16.
REQ-002 Parameter SEL_WIDTH, default 4: command select width; SHALL satisfy 2^SEL_WIDTH >= NB_MODULES.
REQ-003 clk  input  1  clock; all logic on its rising edge.
REQ-004 rst_n  input  1  synchronous, active-low reset.
REQ-005 i_cmd_valid  input  1  command present.
REQ-006 o_cmd_ready  output  1  sequencer can accept a command.
REQ-007 i_cmd_sel  input  SEL_WIDTH  target sub-module index.
REQ-008 i_cmd_timeout  input  32  timeout in clk cycles; 0 = no timeout.
REQ-009 i_abort  input  1  abandon the outstanding command.
REQ-010 o_sel  output  NB_MODULES  one-hot select to target sub-module.
REQ-011 o_args_valid  output  1  one-cycle argument strobe to the selected sub-module.
REQ-012 i_done  input  NB_MODULES  per-sub-module completion flags.
REQ-013 o_busy  output  1  command in flight (state != IDLE).
REQ-014 o_status_valid  output  1  one-cycle completion report strobe.
REQ-015 o_status  output  2  00 OK, 01 TIMEOUT, 10 BAD_SEL, 11 ABORTED.
REQ-016 o_cycles  output  32  WAIT cycles consumed by the reported command.

Function
REQ-017 FSM states: IDLE, ISSUE, WAIT, REPORT.
REQ-018 IDLE: o_cmd_ready=1; a command is accepted when i_cmd_valid=1 in IDLE; i_cmd_sel and i_cmd_timeout are latched on that edge.
REQ-019 Accepted command with i_cmd_sel < NB_MODULES: IDLE->ISSUE. With i_cmd_sel >= NB_MODULES: IDLE->REPORT with status BAD_SEL and o_cycles=0; o_sel stays all-zero.
REQ-020 ISSUE, exactly one cycle: o_sel = one-hot of latched select; o_args_valid=1; cycle counter cleared to 0; i_done and i_abort ignored; next state WAIT.
REQ-021 WAIT: o_sel held; o_args_valid=0; the counter increments each WAIT cycle, so the first WAIT cycle counts as 1.
REQ-022 Only i_done[latched sel] is observed; done bits of other modules are ignored.
REQ-023 Done seen on WAIT cycle k: go to REPORT with status OK and o_cycles=k.
REQ-024 Timeout T != 0, no done by WAIT cycle T: on cycle T go to REPORT with status TIMEOUT and o_cycles=T.
REQ-025 i_abort=1 in WAIT with no done: go to REPORT with status ABORTED and o_cycles = current count.
REQ-026 Simultaneous-event priority on the same WAIT cycle: done > abort > timeout.
REQ-027 T=0: no timeout applies; the counter saturates at 32'hFFFFFFFF and never wraps.
REQ-028 REPORT, exactly one cycle: o_status_valid=1; o_status and o_cycles valid; o_sel=0; next state IDLE.
REQ-029 o_status and o_cycles hold their last reported values until the next REPORT.
REQ-030 o_cmd_ready=0 in ISSUE, WAIT and REPORT; i_cmd_valid is ignored in those states. Minimum command spacing is 4 cycles (IDLE accept, ISSUE, WAIT, REPORT).
REQ-031 o_busy=1 in ISSUE, WAIT and REPORT.

Reset
REQ-032 rst_n=0 at a clock edge forces IDLE from any state, including mid-WAIT; the in-flight command is dropped with no REPORT.
REQ-033 Reset values: o_cmd_ready=1, o_sel=0, o_args_valid=0, o_busy=0, o_status_valid=0, o_status=00, o_cycles=0; internal counter and latched command = 0.
REQ-034 Outputs SHALL take reset values on the first edge with rst_n=0.

Verification
REQ-035 NB_MODULES=4; sel=2, T=10; i_done[2] pulsed on WAIT cycle 3 -> o_sel=4'b0100 with o_args_valid for 1 cycle, then status=00, o_cycles=3, o_status_valid 1 cycle.
REQ-036 sel=1, T=5, no done -> status=01, o_cycles=5, reported 5 cycles after ISSUE.
REQ-037 sel=6 -> status=10, o_cycles=0 in the cycle after accept; o_sel never nonzero.
REQ-038 sel=0, T=4; i_done[0] and i_abort both high on WAIT cycle 4 -> status=00, o_cycles=4. Repeat with i_done[3] instead -> status=11.
REQ-039 sel=3, T=0; rst_n low on WAIT cycle 7 -> outputs at reset values, no o_status_valid; a new command is accepted on the first cycle after reset release.
REQ-040 i_cmd_valid held high continuously with done returned on WAIT cycle 1 -> commands accepted every 4 cycles; o_cmd_ready low in ISSUE, WAIT and REPORT.
